voice_alloc: RTL
================

Name: voice_alloc

Overview:
Polyphonic voice allocator that shares a pool of NUM_VOICES oscillator voices between incoming note events from the keyboard/MIDI front end. Each note-on is mapped to a voice, and that voice's 12-bit frequency word and gate are driven to its oscillator instance. Each note-off releases the matching voice. The block sits between the note-event source and the bank of oscillator voices plus the mixer.

Parameters:
NUM_VOICES, 4, number of oscillator voices managed (2..16)
FREQ_W, 12, frequency word width in Hz; matches the oscillator freq input
KEY_W, 7, note/key code width
AGE_W, 8, per-voice age counter width; saturating

Ports:
clk  in  1  system clock (1 MHz domain, same as oscillators)
rst  in  1  asynchronous, active-high reset
ev_valid  in  1  note event present
ev_ready  out  1  allocator can accept an event
ev_on  in  1  1 = note-on, 0 = note-off
ev_key  in  KEY_W  key code of event
ev_freq  in  FREQ_W  frequency for note-on (ignored on note-off)
voice_freq  out  NUM_VOICES*FREQ_W  packed per-voice frequency; voice i at [i*FREQ_W +: FREQ_W]
voice_gate  out  NUM_VOICES  per-voice gate (1 = sounding)
voice_key  out  NUM_VOICES*KEY_W  packed per-voice key currently owned
drop  out  1  one-cycle pulse: accepted event was discarded
busy_all  out  1  all voice_gate bits high (combinational from voice_gate)

Behaviour:
- Reset values (async):
  - voice_gate = 0, voice_key = 0, voice_freq = 440 for every voice (oscillator never sees a divide-by-zero), all ages = 0.
  - drop = 0; FSM = IDLE; ev_ready = 1.
- FSM states:
  - IDLE: ev_ready=1. When ev_valid&&ev_ready, capture ev_on/key/freq and go to SCAN with idx=0.
  - SCAN: ev_ready=0. Examine voice idx, one per clock. After idx=NUM_VOICES-1, go to COMMIT.
  - COMMIT: ev_ready=0. Apply the result, then return to IDLE.
- Latency: event accepted at edge 0; scan edges 1..NUM_VOICES; outputs update at edge NUM_VOICES+1; ev_ready high again from that edge. Throughput is one event per NUM_VOICES+2 cycles.
- Note-on target selection, priority high to low:
  - (a) lowest-index gated voice whose key == ev_key (retrigger: update freq, age=0).
  - (b) lowest-index voice with gate=0.
  - (c) no free voice: steal if the optional feature is enabled, else drop.
- Note-on commit:
  - target gets gate=1, key=ev_key, freq=ev_freq, age=0.
  - every other gated voice gets age+1, saturating at 2^AGE_W-1.
- Note-on with ev_freq==0: no voice changes; drop pulses at COMMIT.
- Note-off:
  - lowest-index gated voice with key match gets gate=0.
  - freq and key are held (release tail downstream); ages unchanged.
  - no match: no change, no drop.
- drop is high exactly one cycle, on the COMMIT edge, only for discarded note-ons.
- ev_valid deasserting while not in IDLE has no effect; the event is already captured.
- rst mid-operation: captured event discarded, FSM returns to IDLE, all voices return to reset values.

Optional Feature:
VOICE_STEAL_EN
- Defined: case (c) steals the gated voice with the largest age (ties go to lowest index). That voice is reassigned as a normal note-on; drop stays 0.
- Undefined: case (c) discards the event and pulses drop. Age counters still exist for case (a)/(b) bookkeeping; synthesis may prune them.

Decomposition:
- Shared package synth_pkg:
  - FSM state encoding (IDLE, SCAN, COMMIT)
  - FREQ_W and KEY_W defaults
  - DEFAULT_FREQ = 440
  - oscillator clock rate constant 1_000_000
- One sub-module, voice_age_bank: NUM_VOICES saturating AGE_W counters with per-voice clear and a global increment-gated-voices strobe, plus an oldest-index output (combinational argmax, lowest index on ties).

Test Plan:
- Reset then idle: voice_gate=0000, every voice_freq=440, ev_ready=1, drop=0.
- Note-on key 60 freq 262 at edge 0 (NUM_VOICES=4): ev_ready low for edges 1..5; at edge 5 voice 0 gate=1, freq=262, key=60.
- Note-ons keys 60/64/67 then note-off key 64 -> voice_gate=0101; next note-on key 72 freq 523 lands in voice 1.
- Note-on key 60 again (freq 270) while voice 0 holds key 60 -> voice 0 freq=270, age 0, no new voice used.
- Five note-ons keys 60,62,64,65,67 with all four voices busy -> with VOICE_STEAL_EN voice 0 (oldest) becomes key 67 and drop=0; without it all voices unchanged and drop pulses one cycle.
- Note-on freq 0 -> drop pulse, no change. rst asserted during SCAN -> immediately IDLE with reset values, and the captured event never applied.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: allocator FSM encoding,
// default datapath widths and oscillator constants.
package synth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } alloc_state_e;

  localparam int FREQ_W_DEF   = 12;
  localparam int KEY_W_DEF    = 7;
  // Parked frequency so an idle oscillator never divides by zero.
  localparam int DEFAULT_FREQ = 440;
  localparam int OSC_CLK_HZ   = 1_000_000;

endpackage

// File: rtl/voice_age_bank.sv
// Per-voice saturating age counters. A clear zeroes a voice's age; the
// increment strobe ages every gated voice that is not being cleared.
// oldest_idx is the gated voice with the largest age, lowest index on ties.
module voice_age_bank #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_VOICES-1:0] clr,
  input  logic                  inc,
  input  logic [NUM_VOICES-1:0] gate,
  output logic [IDX_W-1:0]      oldest_idx
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;
  logic [AGE_W-1:0]                 best_age;
  logic                             best_ok;

  // Next age per voice: clear wins, otherwise saturating increment of gated voices
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (clr[i]) begin
        age_d[i] = '0;
      end else if (inc && gate[i] && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  // Age registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  // Argmax over gated voices; strict compare keeps the lowest index on ties
  always_comb begin
    oldest_idx = '0;
    best_age   = '0;
    best_ok    = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (gate[i] && (!best_ok || (age_q[i] > best_age))) begin
        best_ok    = 1'b1;
        best_age   = age_q[i];
        oldest_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator. Events are captured in IDLE, voices are
// scanned one per clock in SCAN, and the result is applied in COMMIT.
// Optional build macro: VOICE_STEAL_EN (steal the oldest voice when full
// instead of dropping the note-on).
module voice_alloc
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_W     = FREQ_W_DEF,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int AGE_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [KEY_W-1:0]             ev_key,
  input  logic [FREQ_W-1:0]            ev_freq,
  output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES*KEY_W-1:0]  voice_key,
  output logic                         drop,
  output logic                         busy_all
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VOICES - 1);
  localparam logic [FREQ_W-1:0] FREQ_PARK = FREQ_W'(DEFAULT_FREQ);

  alloc_state_e state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              on_q, on_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              match_found_q, match_found_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic              free_found_q, free_found_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;

  logic [NUM_VOICES-1:0]             gate_q, gate_d;
  logic [NUM_VOICES-1:0][KEY_W-1:0]  vkey_q, vkey_d;
  logic [NUM_VOICES-1:0][FREQ_W-1:0] vfreq_q, vfreq_d;
  logic                              drop_q, drop_d;

  logic [NUM_VOICES-1:0] age_clr;
  logic                  age_inc;
  logic [IDX_W-1:0]      oldest_idx;
  logic [IDX_W-1:0]      tgt;
  logic                  tgt_ok;

  voice_age_bank #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_age (
    .clk        (clk),
    .rst        (rst),
    .clr        (age_clr),
    .inc        (age_inc),
    .gate       (gate_q),
    .oldest_idx (oldest_idx)
  );

  // Next-state, scan bookkeeping and commit of the captured event
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    on_d          = on_q;
    key_d         = key_q;
    freq_d        = freq_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    gate_d        = gate_q;
    vkey_d        = vkey_q;
    vfreq_d       = vfreq_q;
    drop_d        = 1'b0;
    age_clr       = '0;
    age_inc       = 1'b0;
    ev_ready      = 1'b0;
    tgt           = '0;
    tgt_ok        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) begin
          on_d          = ev_on;
          key_d         = ev_key;
          freq_d        = ev_freq;
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          state_d       = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (!match_found_q && gate_q[idx_q] && (vkey_q[idx_q] == key_q)) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!free_found_q && !gate_q[idx_q]) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (on_q) begin
          if (freq_q != '0) begin
            if (match_found_q) begin
              tgt_ok = 1'b1;
              tgt    = match_idx_q;
            end else if (free_found_q) begin
              tgt_ok = 1'b1;
              tgt    = free_idx_q;
            end else begin
`ifdef VOICE_STEAL_EN
              tgt_ok = 1'b1;
              tgt    = oldest_idx;
`endif
            end
          end
          if (tgt_ok) begin
            gate_d[tgt]  = 1'b1;
            vkey_d[tgt]  = key_q;
            vfreq_d[tgt] = freq_q;
            age_clr[tgt] = 1'b1;
            age_inc      = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end else if (match_found_q) begin
          // Release only: key and freq stay for the downstream release tail
          gate_d[match_idx_q] = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured event and voice registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      on_q          <= 1'b0;
      key_q         <= '0;
      freq_q        <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      gate_q        <= '0;
      vkey_q        <= '0;
      vfreq_q       <= {NUM_VOICES{FREQ_PARK}};
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      on_q          <= on_d;
      key_q         <= key_d;
      freq_q        <= freq_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      gate_q        <= gate_d;
      vkey_q        <= vkey_d;
      vfreq_q       <= vfreq_d;
      drop_q        <= drop_d;
    end
  end

  assign voice_gate = gate_q;
  assign voice_key  = vkey_q;
  assign voice_freq = vfreq_q;
  assign drop       = drop_q;
  assign busy_all   = &gate_q;

endmodule
